uarc_bus_link: RTL and testbench

- Point-to-point buffering stage for one UARC bus, between a sending core0's global_send/global_data/global_kill/sender_enables bit and a receiving core0's receiver_* bit.
- Decouples the sender from a receiver that is stalled: accepted send words are queued in a FIFO and presented downstream with a send/ack handshake.
- Kill requests flush the queue, propagate downstream, and are acknowledged upstream only after the receiver acknowledges.

---
 rtl/uarc_bus_link.sv | 107 ++++++++++
 tb/tb_uarc_bus_link.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uarc_bus_link.sv
// Buffering stage for one UARC bus: queues accepted sender words in a small FIFO
// and relays kill requests downstream, acknowledging upstream once the receiver does.
module uarc_bus_link #(
  parameter int WORD_MAG        = 5,
  parameter int FIFO_ADDR_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         up_enable,
  input  logic                         up_send,
  input  logic [(1<<WORD_MAG)-1:0]     up_data,
  output logic                         up_send_ack,
  input  logic                         up_kill,
  output logic                         up_kill_ack,
  output logic                         dn_enable,
  output logic                         dn_send,
  output logic [(1<<WORD_MAG)-1:0]     dn_data,
  input  logic                         dn_send_ack,
  output logic                         dn_kill,
  input  logic                         dn_kill_ack,
  output logic [FIFO_ADDR_WIDTH:0]     level
);

  localparam int WORD_WIDTH = 1 << WORD_MAG;
  localparam int DEPTH      = 1 << FIFO_ADDR_WIDTH;
  localparam logic [FIFO_ADDR_WIDTH:0] FULL = (FIFO_ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {RUN, KILL_WAIT, KILL_DONE} state_e;

  state_e                       state_q, state_d;
  logic [FIFO_ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_ADDR_WIDTH:0]     count_q, count_d;
  logic                         dn_kill_q, dn_kill_d;
  logic [WORD_WIDTH-1:0]        mem_q [DEPTH];
  logic                         push, pop;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dn_kill_d = dn_kill_q;
    push      = 1'b0;
    pop       = 1'b0;
    case (state_q)
      RUN: begin
        if (up_enable && up_kill) begin
          // Kill wins over any send or pop in the same cycle; the queue is dropped.
          state_d   = KILL_WAIT;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          count_d   = '0;
          dn_kill_d = 1'b1;
        end else begin
          push = up_enable && up_send && (count_q != FULL);
          pop  = (count_q != '0) && dn_send_ack;
          if (push) wr_ptr_d = wr_ptr_q + FIFO_ADDR_WIDTH'(1);
          if (pop)  rd_ptr_d = rd_ptr_q + FIFO_ADDR_WIDTH'(1);
          case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_ADDR_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (FIFO_ADDR_WIDTH+1)'(1);
            default: count_d = count_q;
          endcase
        end
      end
      KILL_WAIT: begin
        if (dn_kill_ack) begin
          dn_kill_d = 1'b0;
          state_d   = KILL_DONE;
        end
      end
      KILL_DONE: state_d = RUN;
      default:   state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dn_kill_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dn_kill_q <= dn_kill_d;
    end
  end

  // Storage carries no reset; an empty queue masks the head to zero instead.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= up_data;
  end

  assign up_send_ack = push;
  assign dn_send     = (state_q == RUN) && (count_q != '0);
  assign dn_data     = dn_send ? mem_q[rd_ptr_q] : '0;
  assign dn_kill     = dn_kill_q;
  assign dn_enable   = dn_send | dn_kill;
  assign up_kill_ack = (state_q == KILL_DONE);
  assign level       = count_q;

endmodule

// File: tb/tb_uarc_bus_link.sv
// Scoreboard bench for uarc_bus_link: accepted words are queued as expected and
// checked in order as the receiver side hands them off.
module tb_uarc_bus_link;
  logic        clk = 1'b0;
  logic        reset;
  logic        up_enable, up_send, up_kill;
  logic [31:0] up_data;
  logic        up_send_ack, up_kill_ack;
  logic        dn_enable, dn_send, dn_kill;
  logic [31:0] dn_data;
  logic        dn_send_ack, dn_kill_ack;
  logic [2:0]  level;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_w;

  always #5 clk = ~clk;

  uarc_bus_link dut (
    .clk(clk), .reset(reset),
    .up_enable(up_enable), .up_send(up_send), .up_data(up_data),
    .up_send_ack(up_send_ack), .up_kill(up_kill), .up_kill_ack(up_kill_ack),
    .dn_enable(dn_enable), .dn_send(dn_send), .dn_data(dn_data),
    .dn_send_ack(dn_send_ack), .dn_kill(dn_kill), .dn_kill_ack(dn_kill_ack),
    .level(level)
  );

  // Every handoff to the receiver is checked against the oldest expected word.
  always @(negedge clk) begin
    if (reset === 1'b1 && dn_send === 1'b1 && dn_send_ack === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        $display("FAIL handoff_unexpected got=%h required=<none>", dn_data);
        n_bad++;
      end else begin
        exp_w = exp_q.pop_front();
        if (dn_data !== exp_w) begin
          $display("FAIL handoff_data got=%h required=%h", dn_data, exp_w);
          n_bad++;
        end else begin
          $display("handoff data=%h", dn_data);
        end
      end
    end
  end

  task automatic push_cycle(input logic [31:0] d, input logic exp_ack);
    up_enable = 1'b1; up_send = 1'b1; up_kill = 1'b0; up_data = d;
    @(negedge clk);
    n_cmp++;
    if (up_send_ack !== exp_ack) begin
      $display("FAIL push_ack data=%h got=%b required=%b", d, up_send_ack, exp_ack);
      n_bad++;
    end else begin
      $display("push data=%h ack=%b", d, up_send_ack);
    end
    if (exp_ack) exp_q.push_back(d);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    up_enable = 1'b0; up_send = 1'b0; up_kill = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    reset = 1'b0; up_enable = 1'b0; up_send = 1'b0; up_kill = 1'b0; up_data = '0;
    dn_send_ack = 1'b0; dn_kill_ack = 1'b0;
    #3;
    n_cmp++;
    if ({up_send_ack, dn_send, dn_enable, dn_kill, up_kill_ack} !== 5'b0 || dn_data !== 32'h0 || level !== 3'd0) begin
      $display("FAIL reset_outputs got=ack%b snd%b en%b kill%b kack%b data=%h level=%0d required=all zero",
               up_send_ack, dn_send, dn_enable, dn_kill, up_kill_ack, dn_data, level);
      n_bad++;
    end else $display("reset outputs zero");
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    dn_send_ack = 1'b1;
    push_cycle(32'hA5A5_0001, 1'b1);
    n_cmp++;
    if (dn_send !== 1'b1 || dn_data !== 32'hA5A5_0001) begin
      $display("FAIL basic_latency got=send%b data=%h required=send1 data=a5a50001", dn_send, dn_data);
      n_bad++;
    end else $display("basic latency ok");
    push_cycle(32'hA5A5_0002, 1'b1);
    idle_cycles(1);
    n_cmp++;
    if (level !== 3'd0) begin
      $display("FAIL basic_level got=%0d required=0", level); n_bad++;
    end else $display("basic level=0");
  endtask

  task automatic test_full();
    dn_send_ack = 1'b0;
    for (int i = 1; i <= 4; i++) push_cycle(32'(i), 1'b1);
    push_cycle(32'd5, 1'b0);
    n_cmp++;
    if (level !== 3'd4) begin
      $display("FAIL full_level got=%0d required=4", level); n_bad++;
    end else $display("full level=4");
    dn_send_ack = 1'b1;
    idle_cycles(4);
    dn_send_ack = 1'b0;
    for (int i = 1; i <= 4; i++) push_cycle(32'h10 + 32'(i), 1'b1);
    dn_send_ack = 1'b1;
    idle_cycles(4);
    n_cmp++;
    if (level !== 3'd0 || exp_q.size() != 0) begin
      $display("FAIL wrap_drain got=level%0d pending%0d required=0/0", level, exp_q.size()); n_bad++;
    end else $display("wrap drain ok");
  endtask

  task automatic test_full_pop();
    dn_send_ack = 1'b0;
    for (int i = 1; i <= 4; i++) push_cycle(32'h20 + 32'(i), 1'b1);
    dn_send_ack = 1'b1;
    push_cycle(32'h25, 1'b0);
    n_cmp++;
    if (level !== 3'd3) begin
      $display("FAIL fullpop_level got=%0d required=3", level); n_bad++;
    end else $display("full+pop level=3");
    push_cycle(32'h26, 1'b1);
    n_cmp++;
    if (level !== 3'd3) begin
      $display("FAIL pushpop_level got=%0d required=3", level); n_bad++;
    end else $display("push+pop level=3");
    idle_cycles(3);
    n_cmp++;
    if (level !== 3'd0) begin
      $display("FAIL fullpop_drain got=%0d required=0", level); n_bad++;
    end else $display("full+pop drained");
  endtask

  task automatic test_kill();
    dn_send_ack = 1'b0;
    for (int i = 0; i < 3; i++) push_cycle(32'h30 + 32'(i), 1'b1);
    up_enable = 1'b1; up_kill = 1'b1; up_send = 1'b1; up_data = 32'hDEAD;
    @(negedge clk);
    n_cmp++;
    if (up_send_ack !== 1'b0) begin
      $display("FAIL kill_send_ack got=%b required=0", up_send_ack); n_bad++;
    end else $display("kill beats send");
    @(posedge clk); #1;
    up_kill = 1'b0; up_send = 1'b0; up_enable = 1'b0;
    exp_q.delete();
    dn_send_ack = 1'b1;
    n_cmp++;
    if (dn_kill !== 1'b1 || level !== 3'd0 || dn_send !== 1'b0 || dn_enable !== 1'b1 || up_kill_ack !== 1'b0) begin
      $display("FAIL kill_enter got=kill%b level%0d send%b en%b kack%b required=1/0/0/1/0",
               dn_kill, level, dn_send, dn_enable, up_kill_ack); n_bad++;
    end else $display("kill wait entered");
    @(posedge clk); #1;
    n_cmp++;
    if (dn_kill !== 1'b1) begin
      $display("FAIL kill_hold got=%b required=1", dn_kill); n_bad++;
    end else $display("kill held");
    dn_kill_ack = 1'b1;
    @(posedge clk); #1;
    dn_kill_ack = 1'b0;
    n_cmp++;
    if (dn_kill !== 1'b0 || up_kill_ack !== 1'b1) begin
      $display("FAIL kill_done got=kill%b kack%b required=0/1", dn_kill, up_kill_ack); n_bad++;
    end else $display("kill done pulse");
    push_cycle(32'h0BAD, 1'b0);
    n_cmp++;
    if (up_kill_ack !== 1'b0) begin
      $display("FAIL kill_ack_width got=%b required=0", up_kill_ack); n_bad++;
    end else $display("kill ack one cycle");
    push_cycle(32'h1234, 1'b1);
    idle_cycles(1);
    n_cmp++;
    if (level !== 3'd0) begin
      $display("FAIL post_kill_level got=%0d required=0", level); n_bad++;
    end else $display("post-kill push drained");
  endtask

  task automatic test_reset_mid_kill();
    dn_send_ack = 1'b0;
    push_cycle(32'h40, 1'b1);
    push_cycle(32'h41, 1'b1);
    up_enable = 1'b1; up_kill = 1'b1; up_send = 1'b0;
    @(posedge clk); #1;
    up_kill = 1'b0; up_enable = 1'b0;
    exp_q.delete();
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (dn_kill !== 1'b0 || level !== 3'd0 || up_kill_ack !== 1'b0 || dn_enable !== 1'b0) begin
      $display("FAIL async_reset got=kill%b level%0d kack%b en%b required=0/0/0/0",
               dn_kill, level, up_kill_ack, dn_enable); n_bad++;
    end else $display("async reset mid-kill");
    @(posedge clk); #1;
    reset = 1'b1;
    push_cycle(32'h55, 1'b1);
    dn_send_ack = 1'b1;
    idle_cycles(1);
  endtask

  task automatic test_no_enable();
    dn_send_ack = 1'b0;
    push_cycle(32'h77, 1'b1);
    up_enable = 1'b0; up_send = 1'b1; up_data = 32'h88;
    @(negedge clk);
    n_cmp++;
    if (up_send_ack !== 1'b0) begin
      $display("FAIL noenable_ack got=%b required=0", up_send_ack); n_bad++;
    end else $display("send without enable ignored");
    @(posedge clk); #1;
    up_send = 1'b0;
    n_cmp++;
    if (level !== 3'd1) begin
      $display("FAIL noenable_level got=%0d required=1", level); n_bad++;
    end else $display("level unchanged=1");
    dn_send_ack = 1'b1;
    idle_cycles(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_full_pop();
    test_kill();
    test_reset_mid_kill();
    test_no_enable();
    idle_cycles(2);
    n_cmp++;
    if (exp_q.size() != 0 || level !== 3'd0) begin
      $display("FAIL final_empty got=pending%0d level%0d required=0/0", exp_q.size(), level); n_bad++;
    end else $display("final queue empty");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
